// File: rtl/stc0_pkg.sv
// Shared definitions for the stc0 egress path.
// Holds byte/word/lane widths, the keep and word typedefs, the FIFO beat
// payload (keep + data) and a helper that builds a contiguous keep mask.
package stc0_pkg;

  localparam int unsigned STC0_BYTE_W = 8;
  localparam int unsigned STC0_WORD_W = 32;
  localparam int unsigned STC0_LANES  = 4;
  localparam int unsigned STC0_BEAT_W = STC0_WORD_W + STC0_LANES;

  typedef logic [STC0_LANES-1:0]                   stc0_keep_t;
  typedef logic [STC0_WORD_W-1:0]                  stc0_word_t;
  typedef logic [STC0_LANES-1:0][STC0_BYTE_W-1:0]  stc0_lanes_t;

  // One FIFO entry: keep mask above the data word.
  typedef struct packed {
    stc0_keep_t keep;
    stc0_word_t data;
  } stc0_beat_t;

  // Mask with lanes 0..fill-1 set; fill ranges 0..4.
  function automatic stc0_keep_t stc0_keep_mask(input logic [2:0] fill);
    stc0_keep_t m;
    m = '0;
    for (int i = 0; i < int'(STC0_LANES); i++) begin
      m[i] = (3'(i) < fill);
    end
    return m;
  endfunction

endpackage

// File: rtl/stc0_sync_fifo.sv
// Single-clock FIFO with registered (show-ahead) read data.
// Ports:
//   clk, rst_n        clock, synchronous active-low reset
//   push, wr_data     write request and payload (ignored when full without pop)
//   pop               remove head entry (ignored when empty)
//   rd_data           head entry, registered; zero while empty
//   valid             registered "not empty"
//   level             occupancy 0..DEPTH
module stc0_sync_fifo #(
  parameter int unsigned WIDTH = 36,
  parameter int unsigned DEPTH = 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      push,
  input  logic [WIDTH-1:0]          wr_data,
  input  logic                      pop,
  output logic [WIDTH-1:0]          rd_data,
  output logic                      valid,
  output logic [$clog2(DEPTH):0]    level
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned LVL_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr, wr_ptr_n, rd_ptr_n;
  logic [LVL_W-1:0] level_n;
  logic [WIDTH-1:0] rd_data_n;
  logic             full, do_push, do_pop;

  // Next pointers, occupancy and head data.
  always_comb begin
    full     = (level == LVL_W'(DEPTH));
    do_pop   = pop && valid;
    do_push  = push && (!full || do_pop);
    wr_ptr_n = do_push ? wr_ptr + PTR_W'(1) : wr_ptr;
    rd_ptr_n = do_pop  ? rd_ptr + PTR_W'(1) : rd_ptr;
    level_n  = level;
    if (do_push && !do_pop) begin
      level_n = level + LVL_W'(1);
    end else if (!do_push && do_pop) begin
      level_n = level - LVL_W'(1);
    end
    // The incoming word becomes the head when it lands on the next read slot.
    if (level_n == '0) begin
      rd_data_n = '0;
    end else if (do_push && (wr_ptr == rd_ptr_n)) begin
      rd_data_n = wr_data;
    end else begin
      rd_data_n = mem[rd_ptr_n];
    end
  end

  // Storage array, no reset needed.
  always_ff @(posedge clk) begin
    if (rst_n && do_push) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  // Pointers, level and registered head.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      level   <= '0;
      valid   <= 1'b0;
      rd_data <= '0;
    end else begin
      wr_ptr  <= wr_ptr_n;
      rd_ptr  <= rd_ptr_n;
      level   <= level_n;
      valid   <= (level_n != '0);
      rd_data <= rd_data_n;
    end
  end

endmodule

// File: rtl/stc0_egress_packer.sv
// Packs the stc0_core egress byte stream into 32-bit words with keep masks
// and queues them for a ready/valid consumer. Words arriving at a full queue
// are dropped and counted.
// Ports:
//   ClkIngress, Rstb   clock, synchronous active-low reset
//   EValid, ED         egress byte strobe and byte (no backpressure)
//   Flush              emit a partially assembled word
//   OValid, OReady     head word handshake
//   OD, OKeep          head word (first byte in [7:0]) and lane mask
//   OLevel             queue occupancy
//   Overflow, DropCnt  sticky drop flag and saturating drop count
module stc0_egress_packer
  import stc0_pkg::*;
#(
  parameter int unsigned DEPTH = 8
) (
  input  logic                    ClkIngress,
  input  logic                    Rstb,
  input  logic                    EValid,
  input  logic [7:0]              ED,
  input  logic                    Flush,
  output logic                    OValid,
  input  logic                    OReady,
  output logic [31:0]             OD,
  output logic [3:0]              OKeep,
  output logic [$clog2(DEPTH):0]  OLevel,
  output logic                    Overflow,
  output logic [7:0]              DropCnt
);

  localparam int unsigned LVL_W = $clog2(DEPTH) + 1;

  logic [1:0]   cnt, cnt_n;
  stc0_lanes_t  lanes, lanes_n;
  logic [2:0]   fill;
  logic         done;
  stc0_beat_t   beat_n, pend_beat, head;
  logic         pend_vld;
  logic         pop, full, push, drop;

  // Assembler: place the byte, decide completion, build the outgoing beat.
  always_comb begin
    lanes_n = lanes;
    if (EValid) begin
      lanes_n[cnt] = ED;
    end
    fill        = {1'b0, cnt} + 3'(EValid);
    // A flush with nothing held (and no byte this cycle) does nothing.
    done        = (EValid && (cnt == 2'd3)) || (Flush && (fill != 3'd0));
    cnt_n       = done ? 2'd0 : cnt + 2'(EValid);
    beat_n.keep = stc0_keep_mask(fill);
    beat_n.data = stc0_word_t'(lanes_n);
  end

  // Queue admission: a full queue still accepts when the head leaves this cycle.
  always_comb begin
    pop  = OValid && OReady;
    full = (OLevel == LVL_W'(DEPTH));
    push = pend_vld && (!full || pop);
    drop = pend_vld && full && !pop;
  end

  // Assembly registers, one-cycle completed-word stage, drop bookkeeping.
  always_ff @(posedge ClkIngress) begin
    if (!Rstb) begin
      cnt       <= 2'd0;
      lanes     <= '0;
      pend_vld  <= 1'b0;
      pend_beat <= '0;
      Overflow  <= 1'b0;
      DropCnt   <= 8'd0;
    end else begin
      cnt       <= cnt_n;
      // Clearing after completion keeps unwritten lanes of the next word at zero.
      lanes     <= done ? '0 : lanes_n;
      pend_vld  <= done;
      pend_beat <= beat_n;
      if (drop) begin
        Overflow <= 1'b1;
        if (DropCnt != 8'hFF) begin
          DropCnt <= DropCnt + 8'd1;
        end
      end
    end
  end

  stc0_sync_fifo #(
    .WIDTH (STC0_BEAT_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (ClkIngress),
    .rst_n   (Rstb),
    .push    (push),
    .wr_data (pend_beat),
    .pop     (pop),
    .rd_data (head),
    .valid   (OValid),
    .level   (OLevel)
  );

  assign OD    = head.data;
  assign OKeep = head.keep;

endmodule

// File: tb/tb_stc0_egress_packer.sv
// Randomised scoreboard bench for stc0_egress_packer with directed scenarios.
module tb_stc0_egress_packer;

  localparam int DEPTH = 8;

  logic        ClkIngress = 1'b0;
  logic        Rstb;
  logic        EValid;
  logic [7:0]  ED;
  logic        Flush;
  logic        OValid;
  logic        OReady;
  logic [31:0] OD;
  logic [3:0]  OKeep;
  logic [3:0]  OLevel;
  logic        Overflow;
  logic [7:0]  DropCnt;

  int errors = 0;
  int checks = 0;

  // Reference model state: accepted words in order, bytes of the word in progress.
  logic [35:0] exp_q[$];
  logic [7:0]  m_bytes[$];
  logic        m_pend_v = 1'b0;
  logic [35:0] m_pend = '0;
  logic        m_ovf = 1'b0;
  int          m_drops = 0;
  logic        in_rst = 1'b0;
  logic        started = 1'b0;

  stc0_egress_packer #(.DEPTH(DEPTH)) dut (
    .ClkIngress (ClkIngress),
    .Rstb       (Rstb),
    .EValid     (EValid),
    .ED         (ED),
    .Flush      (Flush),
    .OValid     (OValid),
    .OReady     (OReady),
    .OD         (OD),
    .OKeep      (OKeep),
    .OLevel     (OLevel),
    .Overflow   (Overflow),
    .DropCnt    (DropCnt)
  );

  always #5 ClkIngress = ~ClkIngress;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: bytes gather into words of up to four; a finished word reaches the
  // queue one edge later and is dropped if the queue is full and not popping.
  always @(posedge ClkIngress) begin : model
    logic full_m, pop_m;
    logic [31:0] w;
    int n;
    if (!Rstb) begin
      exp_q.delete();
      m_bytes.delete();
      m_pend_v = 1'b0;
      m_ovf    = 1'b0;
      m_drops  = 0;
      in_rst   = 1'b1;
    end else begin
      in_rst = 1'b0;
      full_m = (exp_q.size() == DEPTH);
      pop_m  = (exp_q.size() != 0) && OReady;
      if (pop_m) exp_q.delete(0);
      if (m_pend_v) begin
        if (!full_m || pop_m) begin
          exp_q.push_back(m_pend);
        end else begin
          m_ovf = 1'b1;
          if (m_drops < 255) m_drops++;
        end
      end
      m_pend_v = 1'b0;
      if (EValid) m_bytes.push_back(ED);
      if (m_bytes.size() == 4 || (Flush && m_bytes.size() != 0)) begin
        n = m_bytes.size();
        w = '0;
        for (int i = 0; i < n; i++) w[8*i +: 8] = m_bytes[i];
        m_pend   = {4'((1 << n) - 1), w};
        m_pend_v = 1'b1;
        m_bytes.delete();
      end
    end
    started = 1'b1;
  end

  // Monitor: compare the presented head and status against the model each cycle.
  always @(negedge ClkIngress) begin
    if (started) begin
      chk("olevel", 64'(OLevel), 64'(exp_q.size()));
      chk("ovalid", 64'(OValid), 64'(exp_q.size() != 0));
      chk("overflow", 64'(Overflow), 64'(m_ovf));
      chk("dropcnt", 64'(DropCnt), 64'(m_drops));
      if (in_rst) begin
        chk("rst_od", 64'(OD), 64'd0);
        chk("rst_okeep", 64'(OKeep), 64'd0);
      end
      if (OValid) begin
        if (exp_q.size() == 0) begin
          chk("head_expected", 64'd0, 64'd1);
        end else begin
          chk("od", 64'(OD), 64'(exp_q[0][31:0]));
          chk("okeep", 64'(OKeep), 64'(exp_q[0][35:32]));
        end
      end
    end
  end

  task automatic step(input logic ev, input logic [7:0] d, input logic fl, input logic rdy);
    EValid = ev;
    ED     = d;
    Flush  = fl;
    OReady = rdy;
    @(posedge ClkIngress);
    #1;
  endtask

  task automatic idle(input int n, input logic rdy);
    for (int i = 0; i < n; i++) step(1'b0, 8'h00, 1'b0, rdy);
  endtask

  task automatic rst_cycle();
    Rstb = 1'b0;
    step(1'b0, 8'h00, 1'b0, 1'b0);
    Rstb = 1'b1;
  endtask

  task automatic words(input int n, input logic rdy);
    for (int i = 0; i < 4 * n; i++) step(1'b1, 8'($urandom), 1'b0, rdy);
  endtask

  initial begin
    Rstb = 1'b0; EValid = 1'b0; ED = 8'h00; Flush = 1'b0; OReady = 1'b0;
    repeat (3) @(posedge ClkIngress);
    #1;
    chk("reset_ovalid", 64'(OValid), 64'd0);
    chk("reset_olevel", 64'(OLevel), 64'd0);
    Rstb = 1'b1;

    // Full word and its two-cycle latency.
    step(1'b1, 8'h11, 1'b0, 1'b1);
    step(1'b1, 8'h22, 1'b0, 1'b1);
    step(1'b1, 8'h33, 1'b0, 1'b1);
    step(1'b1, 8'h44, 1'b0, 1'b1);
    chk("lat_not_yet", 64'(OValid), 64'd0);
    idle(1, 1'b1);
    chk("lat_valid", 64'(OValid), 64'd1);
    chk("word_full_od", 64'(OD), 64'h44332211);
    chk("word_full_keep", 64'(OKeep), 64'hF);
    idle(1, 1'b1);
    chk("single_beat", 64'(OValid), 64'd0);

    // Partial word by flush, then a lone flush.
    step(1'b1, 8'hAA, 1'b0, 1'b1);
    step(1'b1, 8'hBB, 1'b0, 1'b1);
    step(1'b0, 8'h00, 1'b1, 1'b1);
    idle(1, 1'b1);
    chk("flush_od", 64'(OD), 64'h0000BBAA);
    chk("flush_keep", 64'(OKeep), 64'h3);
    step(1'b0, 8'h00, 1'b1, 1'b1);
    idle(3, 1'b1);
    chk("lone_flush", 64'(OValid), 64'd0);

    // Byte together with flush at lane 2, then a fresh word from lane 0.
    step(1'b1, 8'h01, 1'b0, 1'b1);
    step(1'b1, 8'h02, 1'b0, 1'b1);
    step(1'b1, 8'hCC, 1'b1, 1'b1);
    idle(1, 1'b1);
    chk("flush_byte_od", 64'(OD), 64'h00CC0201);
    chk("flush_byte_keep", 64'(OKeep), 64'h7);
    step(1'b1, 8'h55, 1'b0, 1'b1);
    step(1'b1, 8'h66, 1'b0, 1'b1);
    step(1'b1, 8'h77, 1'b0, 1'b1);
    step(1'b1, 8'h88, 1'b0, 1'b1);
    idle(1, 1'b1);
    chk("after_flush_od", 64'(OD), 64'h88776655);
    idle(3, 1'b1);

    // Ten words into a stalled queue: two drops.
    words(10, 1'b0);
    idle(3, 1'b0);
    chk("ovf_level", 64'(OLevel), 64'd8);
    chk("ovf_flag", 64'(Overflow), 64'd1);
    chk("ovf_drops", 64'(DropCnt), 64'd2);
    idle(12, 1'b1);

    // Word arriving at a full queue in the same cycle as a pop.
    rst_cycle();
    words(8, 1'b0);
    idle(3, 1'b0);
    words(1, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b1);
    idle(2, 1'b0);
    chk("pushpop_level", 64'(OLevel), 64'd8);
    chk("pushpop_ovf", 64'(Overflow), 64'd0);
    chk("pushpop_drops", 64'(DropCnt), 64'd0);
    idle(12, 1'b1);

    // Reset mid-word with words queued.
    words(3, 1'b0);
    step(1'b1, 8'hE1, 1'b0, 1'b0);
    step(1'b1, 8'hE2, 1'b0, 1'b0);
    rst_cycle();
    chk("midrst_ovalid", 64'(OValid), 64'd0);
    chk("midrst_olevel", 64'(OLevel), 64'd0);
    step(1'b1, 8'hD0, 1'b0, 1'b1);
    step(1'b1, 8'hD1, 1'b0, 1'b1);
    step(1'b1, 8'hD2, 1'b0, 1'b1);
    step(1'b1, 8'hD3, 1'b0, 1'b1);
    idle(1, 1'b1);
    chk("midrst_word", 64'(OD), 64'hD3D2D1D0);
    idle(3, 1'b1);

    // Random traffic, flushes, backpressure and occasional resets.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 299) == 0) begin
        rst_cycle();
      end else begin
        step(1'($urandom_range(0, 9) < 7), 8'($urandom),
             1'($urandom_range(0, 9) == 0), 1'($urandom_range(0, 9) < 5));
      end
    end

    idle(20, 1'b1);
    chk("drain_model_empty", 64'(exp_q.size()), 64'd0);
    chk("drain_level", 64'(OLevel), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/stc0_egress_packer.md
STC0_EGRESS_PACKER -- requirements
Module: stc0_egress_packer

Interface
REQ-001 The block SHALL have parameter DEPTH, default 8, FIFO depth in 32-bit words (power of two, 2..64).
REQ-002 The block SHALL have port ClkIngress, input, 1, the single clock, the same clock that drives stc0_core.
REQ-003 The block SHALL have port Rstb, input, 1, reset: synchronous, active-low.
REQ-004 The block SHALL have port EValid, input, 1, byte-valid strobe from stc0_core egress; there is no backpressure.
REQ-005 The block SHALL have port ED, input, 8, egress byte, qualified by EValid.
REQ-006 The block SHALL have port Flush, input, 1, single-cycle request to emit a partially assembled word.
REQ-007 The block SHALL have port OValid, output, 1, head word available.
REQ-008 The block SHALL have port OReady, input, 1, consumer accepts head word.
REQ-009 The block SHALL have port OD, output, 32, head word; the first received byte is in [7:0].
REQ-010 The block SHALL have port OKeep, output, 4, per-lane byte-valid mask of the head word.
REQ-011 The block SHALL have port OLevel, output, $clog2(DEPTH)+1, FIFO occupancy.
REQ-012 The block SHALL have port Overflow, output, 1, sticky word-drop flag.
REQ-013 The block SHALL have port DropCnt, output, 8, count of dropped words, saturating at 255.

Function
REQ-014 The assembler SHALL hold a lane index Cnt (0..3); each cycle with EValid=1, ED is written to lane Cnt and Cnt increments, wrapping 3->0.
REQ-015 A word SHALL complete when EValid=1 and Cnt=3, with OKeep=4'b1111.
REQ-016 On Flush=1 with Cnt>0 and EValid=0, the assembler SHALL complete a partial word, OKeep = lanes 0..Cnt-1, and reset Cnt to 0.
REQ-017 On Flush=1 and EValid=1 together, the byte SHALL be included first; the word SHALL complete with OKeep covering lanes 0..Cnt, and Cnt SHALL become 0.
REQ-018 Flush=1 with Cnt=0 and EValid=0 SHALL be a no-op.
REQ-019 Unwritten lanes of a completed word SHALL read 8'h00 on OD.
REQ-020 A completed word SHALL be pushed into the FIFO in the cycle after its last byte; when pushed into an empty FIFO, OValid SHALL assert one cycle later, i.e. 2 cycles after the last byte.
REQ-021 The FIFO head SHALL pop on any cycle with OValid=1 and OReady=1; OD and OKeep SHALL hold stable while OValid=1 and OReady=0.
REQ-022 A push to a full FIFO SHALL be accepted if a pop occurs in the same cycle.
REQ-023 A push to a full FIFO without a same-cycle pop SHALL drop the word, set Overflow=1, and increment DropCnt (saturating at 255).
REQ-024 Assembly SHALL continue unaffected during drops.
REQ-025 A push and a pop in the same cycle on a non-full FIFO SHALL leave OLevel unchanged.
REQ-026 OLevel SHALL count 0..DEPTH; pointers SHALL wrap modulo DEPTH.
REQ-027 OValid SHALL equal (OLevel != 0).

Reset
REQ-028 While Rstb=0 at a rising ClkIngress edge, the block SHALL clear Cnt, the assembly register, the FIFO pointers, OLevel, Overflow and DropCnt.
REQ-029 While in reset, the outputs SHALL be OValid=0, OD=0, OKeep=0, OLevel=0, Overflow=0, DropCnt=0.
REQ-030 A reset asserted mid-word SHALL discard the partial word and all queued words; no word is emitted for them.
REQ-031 EValid and Flush SHALL be ignored in any cycle with Rstb=0.
REQ-032 Overflow and DropCnt SHALL clear only on reset.

Structure
REQ-033 The shared package stc0_pkg SHALL hold STC0_BYTE_W=8, STC0_WORD_W=32, STC0_LANES=4, and the typedefs stc0_keep_t (4 bits) and stc0_word_t.
REQ-034 The storage SHALL be one sub-module, stc0_sync_fifo, parameterised by width (36 bits: 32 data + 4 keep) and DEPTH, with registered read data.
REQ-035 The assembler and drop logic SHALL reside in stc0_egress_packer.

Verification
REQ-036 Bytes 11,22,33,44 on consecutive cycles with OReady=1 -> OD=32'h44332211, OKeep=4'hF, OValid 2 cycles after byte 44, single beat.
REQ-037 Bytes AA,BB, then Flush alone -> OD=32'h0000BBAA, OKeep=4'h3; a subsequent lone Flush produces no word.
REQ-038 Byte CC with Flush in the same cycle while Cnt=2 -> OKeep=4'h7 with CC in lane 2; Cnt=0 afterwards.
REQ-039 OReady=0, 10 full words with DEPTH=8 -> OLevel=8, Overflow=1, DropCnt=2; draining yields the first 8 words in order.
REQ-040 With the FIFO full, a 9th word completing in the same cycle as a pop -> no drop, Overflow stays 0, OLevel stays 8.
REQ-041 Rstb low for one cycle after 2 bytes and with 3 words queued -> OValid=0, OLevel=0; the next 4 bytes form a fresh word with the first of them in lane 0.
